uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//   Memory-mapped UART transmitter peripheral, sitting downstream of the MIO bus (Peripheral_in) next to SPIO/Multi_8CH32.
//   CPU stores bytes to the UART address, and MIO_BUS decodes a write strobe for it.
//   Bytes queue in a FIFO and are serialised 8N1, LSB first, on txd. A status word is returned to MIO_BUS for CPU polling.
// PARAMETERS
//   CLK_HZ   100_000_000  frequency of clk (clk_100mhz domain)
//   BAUD     115200       line rate; DIVISOR = CLK_HZ/BAUD (integer, >=2; 868 at defaults)
//   DEPTH    16           FIFO entries, power of 2, 2..256
// PORTS
//   clk         in   1   clock, rising edge
//   RSTN        in   1   synchronous reset, active low
//   EN          in   1   bus write strobe, data port (from MIO_BUS decode)
//   P_Data      in   32  bus write data; only [7:0] used
//   clr_ovf     in   1   bus write strobe, control port; clears overflow flag
//   status_out  out  32  {12'b0, ovf[19], busy[18], full[17], empty[16], count[15:0]}
//   txd         out  1   serial line, idle high, registered
// BEHAVIOUR
//   Reset (RSTN=0 at edge): FIFO pointers/count=0, FSM=IDLE, baud counter=0, ovf=0, txd=1.
//     Reset values: status_out=0x0001_0000 (empty=1). Reset mid-frame aborts the frame: txd=1 from that edge.
//   Push: EN=1 at edge with count<DEPTH -> P_Data[7:0] written at wr_ptr, count+1.
//     EN=1 with count==DEPTH and no pop in the same cycle -> byte dropped, ovf<=1 (sticky).
//     Simultaneous push+pop while full -> push accepted, count unchanged, ovf unchanged.
//   clr_ovf=1 -> ovf<=0. If an overflow occurs in the same cycle, set wins (ovf<=1).
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//   FSM states: IDLE, START, DATA, STOP. Each bit period = DIVISOR clk cycles, via baud counter 0..DIVISOR-1.
//     IDLE : txd=1. If count!=0 at edge -> pop rd_ptr into shift reg, txd<=0, baud cnt<=0, -> START.
//     START: at cnt==DIVISOR-1 -> txd<=shift[0], bit idx<=0, -> DATA.
//     DATA : at cnt==DIVISOR-1 -> shift>>=1, idx+1. txd<=next bit; after idx 7 txd<=1, -> STOP.
//     STOP : at cnt==DIVISOR-1 -> if count!=0 pop next byte, txd<=0, -> START (back-to-back, no idle gap),
//            else -> IDLE.
//   Latency: write sampled at edge k into empty FIFO with FSM IDLE -> txd falls at edge k+1.
//     Frame = 10*DIVISOR cycles. Next frame starts exactly 10*DIVISOR cycles after the previous start bit.
//   busy = (state!=IDLE). empty = (count==0). full = (count==DEPTH). status_out is registered-state combinational.
//   The pop happens only on the FSM load edge. A pop from an empty FIFO is impossible by construction.
// STRUCTURE
//   Shared header (header.vh): UART_ADDR/UART_CTRL_ADDR decode constants for MIO_BUS;
//     status bit index defines (UART_ST_OVF=19, BUSY=18, FULL=17, EMPTY=16); FSM state encodings.
//   Sub-module uart_fifo (sync FIFO, DEPTH x 8, push/pop/count/full/empty). FSM, baud counter and shifter stay in the top.
// TESTING  (sim with CLK_HZ=1000, BAUD=100 -> DIVISOR=10, DEPTH=4)
//   1 Reset: hold RSTN=0 two cycles -> txd=1, status_out=0x0001_0000.
//   2 Single byte: EN=1, P_Data=0x0000_00A5 one cycle at edge k -> txd=0 at k+1 for 10 cycles.
//     Then 1,0,1,0,0,1,0,1 (10 cycles each), stop=1. busy=0 at k+101.
//   3 Back-to-back: push 0x55,0x0F on consecutive cycles -> second start bit at exactly k+1+100; no idle gap.
//   4 Overflow: push 6 bytes 0x01..0x06 on consecutive cycles.
//     0x01 pops at once, 0x02..0x05 fill the FIFO (full=1), 0x06 dropped, ovf=1.
//     The line shows 0x01..0x05 only. clr_ovf=1 -> ovf=0.
//   5 Full push+pop: FIFO full, push 0x77 on the STOP->START pop edge -> accepted, count stays 4, ovf=0.
//     0x77 transmitted last.
//   6 Reset mid-frame: RSTN=0 during DATA bit 3 -> txd=1 next edge, status empty. The remaining byte is never sent.

Source files
------------

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the UART transmitter peripheral.
//   - Bus decode addresses used by MIO_BUS to generate the EN / clr_ovf strobes.
//   - Bit positions of the flags inside status_out.
//   - Transmit FSM state encoding.
package uart_tx_periph_pkg;

    // MIO_BUS decode constants: data port and control (clear-overflow) port.
    localparam logic [31:0] UART_ADDR      = 32'hE000_0000;
    localparam logic [31:0] UART_CTRL_ADDR = 32'hE000_0004;

    // status_out layout: {12'b0, ovf, busy, full, empty, count[15:0]}
    localparam int unsigned UART_ST_OVF   = 19;
    localparam int unsigned UART_ST_BUSY  = 18;
    localparam int unsigned UART_ST_FULL  = 17;
    localparam int unsigned UART_ST_EMPTY = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    // Clock cycles per bit period.
    function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous byte FIFO, Depth x 8, with registered occupancy count.
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    synchronous reset, active low (clears pointers and count)
//   push_i    write request; accepted when not full, or when full with a pop in the same cycle
//   wdata_i   byte to write
//   pop_i     read request; caller guarantees the FIFO is not empty
//   rdata_o   byte at the read pointer (combinational read)
//   count_o   number of stored entries, 0..Depth
//   full_o    count_o == Depth
//   empty_o   count_o == 0
module uart_fifo #(
    parameter  int unsigned Depth = 16,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [7:0]      wdata_i,
    input  logic            pop_i,
    output logic [7:0]      rdata_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            push_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers are log2(Depth) bits wide and wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: bytes written through the bus strobe EN are queued
// in a FIFO and sent 8N1, LSB first, on txd. A status word is offered for CPU polling.
// Ports:
//   clk         clock, rising edge
//   RSTN        synchronous reset, active low; aborts any frame in flight
//   EN          bus write strobe for the data port
//   P_Data      bus write data; only [7:0] is used
//   clr_ovf     bus write strobe for the control port; clears the overflow flag
//   status_out  {12'b0, ovf, busy, full, empty, count[15:0]}
//   txd         serial line, idle high, registered
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 16
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        EN,
    input  logic [31:0] P_Data,
    input  logic        clr_ovf,
    output logic [31:0] status_out,
    output logic        txd
);

    localparam int unsigned Divisor  = calc_divisor(CLK_HZ, BAUD);
    localparam int unsigned CntW     = $clog2(Divisor);
    localparam int unsigned FifoCntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Divisor - 1);

    tx_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;

    logic                fifo_pop;
    logic [7:0]          fifo_rdata;
    logic [FifoCntW-1:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                bit_end;
    logic                overflow;

    logic unused_pdata;
    assign unused_pdata = ^P_Data[31:8];

    uart_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (RSTN),
        .push_i  (EN),
        .wdata_i (P_Data[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end = (cnt_q == CntMax);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    txd_d    = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    txd_d   = shift_q[0];
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        txd_d    = 1'b0;
                        state_d  = StStart;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // A push into a full FIFO is only lost if no pop frees a slot this cycle.
    assign overflow = EN && fifo_full && !fifo_pop;

    always_comb begin
        ovf_d = ovf_q;
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign txd = txd_q;

    always_comb begin
        status_out                = '0;
        status_out[UART_ST_OVF]   = ovf_q;
        status_out[UART_ST_BUSY]  = (state_q != StIdle);
        status_out[UART_ST_FULL]  = fifo_full;
        status_out[UART_ST_EMPTY] = fifo_empty;
        status_out[15:0]          = 16'(fifo_count);
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
module tb_uart_tx_periph;

    localparam int unsigned ClkHz    = 1000;
    localparam int unsigned Baud     = 100;
    localparam int unsigned Depth    = 4;
    localparam int          D        = ClkHz / Baud;
    localparam int          FrameLen = 10 * D;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        en    = 1'b0;
    logic        clr   = 1'b0;
    logic [31:0] pdata = '0;
    logic [31:0] status;
    logic        txd;

    always #5 clk = ~clk;

    uart_tx_periph #(
        .CLK_HZ (ClkHz),
        .BAUD   (Baud),
        .DEPTH  (Depth)
    ) dut (
        .clk        (clk),
        .RSTN       (rstn),
        .EN         (en),
        .P_Data     (pdata),
        .clr_ovf    (clr),
        .status_out (status),
        .txd        (txd)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        txd;
        logic [31:0] status;
    } cyc_exp_t;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_exp_t;

    cyc_exp_t   cyc_q[$];
    frame_exp_t frame_q[$];

    // Reference model: a byte queue plus "cycles left in the current frame".
    logic [7:0] m_fifo[$];
    int         m_left  = 0;
    logic [7:0] m_byte  = '0;
    logic       m_ovf   = 1'b0;
    int         rst_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Line level implied by the frame position: start 0, data LSB first, stop 1.
    function automatic logic model_txd();
        int bitn;
        if (m_left == 0) return 1'b1;
        bitn = (FrameLen - m_left) / D;
        if (bitn == 0) return 1'b0;
        if (bitn == 9) return 1'b1;
        return m_byte[bitn-1];
    endfunction

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step(input logic r, input logic e, input logic [7:0] d, input logic c);
        int       edge_no;
        logic     can_pop;
        logic     was_full;
        logic     ovf_now;
        cyc_exp_t x;
        edge_no = cyc + 1;
        if (!r) begin
            m_fifo.delete();
            frame_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
            rst_cnt++;
        end else begin
            can_pop  = (m_left <= 1) && (m_fifo.size() > 0);
            was_full = (m_fifo.size() == Depth);
            if (can_pop) begin
                m_byte = m_fifo.pop_front();
                m_left = FrameLen;
                frame_q.push_back('{data: m_byte, start: edge_no});
            end else if (m_left > 0) begin
                m_left--;
            end
            ovf_now = e && was_full && !can_pop;
            if (e && !ovf_now) m_fifo.push_back(d);
            if (ovf_now) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        x.txd    = model_txd();
        x.status = {12'b0, m_ovf, (m_left > 0), (m_fifo.size() == Depth),
                    (m_fifo.size() == 0), 16'(m_fifo.size())};
        cyc_q.push_back(x);
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] d, input logic c);
        @(negedge clk);
        rstn       = r;
        en         = e;
        pdata      = $urandom;
        pdata[7:0] = d;
        clr        = c;
        model_step(r, e, d, c);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycle monitor: txd and status_out after every edge.
    initial begin : cyc_mon
        cyc_exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                x = cyc_q.pop_front();
                check("txd", 32'(txd), 32'(x.txd));
                check("status", status, x.status);
            end
        end
    end

    // Frame monitor: decode each frame from the line, mid-bit sampling.
    initial begin : frame_mon
        int         t0;
        int         r0;
        logic [7:0] b;
        logic       stop_bit;
        frame_exp_t f;
        forever begin
            @(posedge clk);
            #1;
            if (txd === 1'b0) begin
                t0 = cyc;
                r0 = rst_cnt;
                for (int i = 0; i < 8; i++) begin
                    wait_cyc(t0 + (i + 1) * D + D / 2);
                    b[i] = txd;
                end
                wait_cyc(t0 + 9 * D + D / 2);
                stop_bit = txd;
                if (rst_cnt == r0) begin
                    if (frame_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected at cycle %0d: got byte 0x%0h, expected none",
                                 t0, b);
                    end else begin
                        f = frame_q.pop_front();
                        check("frame_data", 32'(b), 32'(f.data));
                        check("frame_start", 32'(t0), 32'(f.start));
                        check("stop_bit", 32'(stop_bit), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held two cycles
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        idle(3);

        // Single byte
        cycle(1'b1, 1'b1, 8'hA5, 1'b0);
        idle(FrameLen + 5);

        // Back-to-back frames
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        cycle(1'b1, 1'b1, 8'h0F, 1'b0);
        idle(2 * FrameLen + 5);

        // Overflow, then clear
        for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        idle(5 * FrameLen + 5);

        // Full FIFO, push on the stop->start pop edge
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0);
        idle(FrameLen - 4);
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        idle(6 * FrameLen + 5);

        // Reset during data bit 3; the queued byte must never appear
        cycle(1'b1, 1'b1, 8'hC3, 1'b0);
        cycle(1'b1, 1'b1, 8'h3C, 1'b0);
        idle(43);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        idle(2 * FrameLen);

        // Random traffic, bursty enough to overflow now and then
        for (int n = 0; n < 3000; n++) begin
            cycle(1'b1, ($urandom_range(0, 29) == 0), 8'($urandom),
                  ($urandom_range(0, 99) == 0));
        end

        idle((Depth + 1) * FrameLen + 10);
        repeat (2) @(posedge clk);
        #2;
        check("frames_left", 32'(frame_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
